// File: rtl/cdf_accumulator_if.sv
// ----------------------------------------------------------------------------
// cdf_accumulator_if
//   Bundles the start/status signals and the scratch-memory bus of the CDF
//   accumulator.
//   master : the accumulator (drives addresses, write data, status)
//   slave  : scratch memory / controller side
//   Signals:
//     enable              start request
//     cdf_sc_mem_rd_addr  scratch read address (read port 1)
//     cdf_sc_mem_rd_data  scratch read data, lane k = bits [32k+31:32k]
//     cdf_sc_mem_wt_addr  scratch write address
//     cdf_sc_mem_wt_data  CDF word, same lane packing as the histogram
//     cdf_sc_mem_wt_en    write strobe, one cycle per word
//     busy                operation in progress
//     cdf_sc_mem_wt_done  one-cycle pulse after the last word is written
//     cdf_min             first non-zero CDF value
// ----------------------------------------------------------------------------
interface cdf_accumulator_if;
    logic         enable;
    logic [15:0]  cdf_sc_mem_rd_addr;
    logic [127:0] cdf_sc_mem_rd_data;
    logic [15:0]  cdf_sc_mem_wt_addr;
    logic [127:0] cdf_sc_mem_wt_data;
    logic         cdf_sc_mem_wt_en;
    logic         busy;
    logic         cdf_sc_mem_wt_done;
    logic [31:0]  cdf_min;

    modport master (
        input  enable, cdf_sc_mem_rd_data,
        output cdf_sc_mem_rd_addr, cdf_sc_mem_wt_addr, cdf_sc_mem_wt_data,
               cdf_sc_mem_wt_en, busy, cdf_sc_mem_wt_done, cdf_min
    );

    modport slave (
        output enable, cdf_sc_mem_rd_data,
        input  cdf_sc_mem_rd_addr, cdf_sc_mem_wt_addr, cdf_sc_mem_wt_data,
               cdf_sc_mem_wt_en, busy, cdf_sc_mem_wt_done, cdf_min
    );
endinterface

// File: rtl/cdf_accumulator.sv
// ----------------------------------------------------------------------------
// cdf_accumulator
//   Histogram-equalization stage. On a start pulse it reads NUM_WORDS
//   histogram words (4 x 32-bit bins each) from scratch memory, forms the
//   running cumulative sum and writes the CDF back in the same packing.
//   cdf_min reports the first non-zero CDF value (0 if none).
//   Ports:
//     clk    single clock, rising edge
//     reset  synchronous, active-high
//     bus    cdf_accumulator_if.master (start, scratch bus, status)
//   Per word: READ (issue address) -> ACC (data arrives, prefix sums)
//   -> WRITE (one write strobe). 32-bit arithmetic wraps modulo 2^32.
// ----------------------------------------------------------------------------
module cdf_accumulator #(
    parameter logic [15:0] HIST_BASE = 16'h0000,
    parameter logic [15:0] CDF_BASE  = 16'h0040,
    parameter int          NUM_WORDS = 64
) (
    input  logic               clk,
    input  logic               reset,
    cdf_accumulator_if.master  bus
);

    localparam int          LANES    = 4;
    localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ACC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]             sum_q,     sum_d;
    logic [15:0]             idx_q,     idx_d;
    logic                    found_q,   found_d;
    logic [31:0]             cdf_min_q, cdf_min_d;
    logic [15:0]             rd_addr_q, rd_addr_d;
    logic [15:0]             wt_addr_q, wt_addr_d;
    logic [127:0]            wt_data_q, wt_data_d;

    logic [LANES-1:0][31:0]  hist_lane;
    logic [LANES-1:0][31:0]  cdf_lane;
    logic [31:0]             run_sum;
    logic                    nz_found;
    logic [31:0]             nz_val;

    // ------------------------------------------------------------------------
    // Lane prefix sums and first-non-zero search
    // ------------------------------------------------------------------------
    assign hist_lane = bus.cdf_sc_mem_rd_data;

    always_comb begin
        run_sum = sum_q;
        for (int k = 0; k < LANES; k++) begin
            run_sum     = run_sum + hist_lane[k];
            cdf_lane[k] = run_sum;
        end
    end

    // Scan high to low so the lowest-index non-zero lane wins.
    always_comb begin
        nz_found = 1'b0;
        nz_val   = 32'd0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (cdf_lane[k] != 32'd0) begin
                nz_found = 1'b1;
                nz_val   = cdf_lane[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.enable) state_d = S_READ;
            S_READ:  state_d = S_ACC;
            S_ACC:   state_d = S_WRITE;
            S_WRITE: state_d = (idx_q == LAST_IDX) ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (Moore strobes) and datapath next-state
    // ------------------------------------------------------------------------
    always_comb begin
        sum_d     = sum_q;
        idx_d     = idx_q;
        found_d   = found_q;
        cdf_min_d = cdf_min_q;
        rd_addr_d = rd_addr_q;
        wt_addr_d = wt_addr_q;
        wt_data_d = wt_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    sum_d     = 32'd0;
                    idx_d     = 16'd0;
                    found_d   = 1'b0;
                    cdf_min_d = 32'd0;
                    rd_addr_d = HIST_BASE;
                end
            end
            S_ACC: begin
                wt_data_d = cdf_lane;
                wt_addr_d = CDF_BASE + idx_q;
                sum_d     = cdf_lane[LANES-1];
                if (!found_q && nz_found) begin
                    cdf_min_d = nz_val;
                    found_d   = 1'b1;
                end
            end
            S_WRITE: begin
                // Read address is staged here so it is already stable for
                // the whole READ cycle of the next word.
                if (idx_q != LAST_IDX) begin
                    idx_d     = idx_q + 16'd1;
                    rd_addr_d = HIST_BASE + idx_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.cdf_sc_mem_wt_en   = (state_q == S_WRITE);
        bus.cdf_sc_mem_wt_done = (state_q == S_DONE);
        bus.busy               = (state_q == S_READ) || (state_q == S_ACC) ||
                                 (state_q == S_WRITE);
        bus.cdf_sc_mem_rd_addr = rd_addr_q;
        bus.cdf_sc_mem_wt_addr = wt_addr_q;
        bus.cdf_sc_mem_wt_data = wt_data_q;
        bus.cdf_min            = cdf_min_q;
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q     <= 32'd0;
            idx_q     <= 16'd0;
            found_q   <= 1'b0;
            cdf_min_q <= 32'd0;
            rd_addr_q <= 16'd0;
            wt_addr_q <= 16'd0;
            wt_data_q <= 128'd0;
        end else begin
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            found_q   <= found_d;
            cdf_min_q <= cdf_min_d;
            rd_addr_q <= rd_addr_d;
            wt_addr_q <= wt_addr_d;
            wt_data_q <= wt_data_d;
        end
    end

endmodule

// File: tb/tb_cdf_accumulator.sv
// ----------------------------------------------------------------------------
// tb_cdf_accumulator
//   Scoreboard bench: expected CDF words are queued when a run starts and
//   popped as write strobes appear. Scratch memory is a one-cycle registered
//   read model; writes are checked, not stored.
// ----------------------------------------------------------------------------
module tb_cdf_accumulator;

    localparam logic [15:0] HIST_BASE = 16'h0000;
    localparam logic [15:0] CDF_BASE  = 16'h0040;
    localparam int          NW        = 64;

    typedef struct packed {
        logic [15:0]  a;
        logic [127:0] d;
    } wr_t;

    logic clk;
    logic reset;

    cdf_accumulator_if ifc ();

    cdf_accumulator #(
        .HIST_BASE (HIST_BASE),
        .CDF_BASE  (CDF_BASE),
        .NUM_WORDS (NW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] mem [0:255];
    logic [31:0]  h   [0:255];

    always @(posedge clk) ifc.cdf_sc_mem_rd_data <= mem[ifc.cdf_sc_mem_rd_addr[7:0]];

    wr_t sb[$];
    int  n_chk, n_err;
    int  rel, wr_run, done_run, first_rel, done_rel;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_mem();
        for (int w = 0; w < NW; w++)
            for (int k = 0; k < 4; k++)
                mem[8'(HIST_BASE) + 8'(w)][32*k +: 32] = h[4*w + k];
    endtask

    task automatic build_sb();
        logic [31:0]  s;
        logic [127:0] d;
        sb.delete();
        s = 32'd0;
        for (int w = 0; w < NW; w++) begin
            for (int k = 0; k < 4; k++) begin
                s = s + h[4*w + k];
                d[32*k +: 32] = s;
            end
            sb.push_back({CDF_BASE + 16'(w), d});
        end
    endtask

    // One cycle: advance to the falling edge and check any write/done seen.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        rel++;
        if (ifc.cdf_sc_mem_wt_en) begin
            if (wr_run == 0) first_rel = rel;
            wr_run++;
            if (sb.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("wt_addr", ifc.cdf_sc_mem_wt_addr, e.a);
                chk("wt_data", ifc.cdf_sc_mem_wt_data, e.d);
            end
            chk("rd_wt_addr_equal", ifc.cdf_sc_mem_rd_addr == ifc.cdf_sc_mem_wt_addr, 0);
        end
        if (ifc.cdf_sc_mem_wt_done) begin
            done_run++;
            done_rel = rel;
        end
    endtask

    // p1/p2: cycles in which enable is re-pulsed (0 = none)
    // rst_at: cycle in which reset is asserted (0 = none)
    task automatic run(input string tag, input int p1, input int p2, input int rst_at,
                       input logic [31:0] exp_min);
        load_mem();
        build_sb();
        wr_run = 0; done_run = 0; first_rel = 0; done_rel = 0;
        ifc.enable = 1'b1;
        rel = 0;
        tick();
        ifc.enable = 1'b0;
        chk({tag, "_busy_start"}, ifc.busy, 1);
        chk({tag, "_min_cleared"}, ifc.cdf_min, 0);
        while (rel < 400) begin
            if (rst_at == 0 && done_run != 0) break;
            if (rst_at != 0 && rel >= 260) break;
            ifc.enable = (rel == p1) || (rel == p2);
            reset      = (rst_at != 0) && (rel == rst_at);
            tick();
        end
        ifc.enable = 1'b0;
        reset      = 1'b0;
        repeat (5) tick();
        if (rst_at != 0) begin
            chk({tag, "_no_done"}, done_run, 0);
            chk({tag, "_writes"}, wr_run, rst_at / 3);
            chk({tag, "_busy_idle"}, ifc.busy, 0);
            chk({tag, "_min_reset"}, ifc.cdf_min, 0);
            sb.delete();
        end else begin
            chk({tag, "_done_count"}, done_run, 1);
            chk({tag, "_done_cycle"}, done_rel, 3*NW + 1);
            chk({tag, "_writes"}, wr_run, NW);
            chk({tag, "_first_wr"}, first_rel, 3);
            chk({tag, "_sb_left"}, sb.size(), 0);
            chk({tag, "_busy_idle"}, ifc.busy, 0);
            chk({tag, "_cdf_min"}, ifc.cdf_min, exp_min);
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0; rel = 0;
        wr_run = 0; done_run = 0; first_rel = 0; done_rel = 0;
        ifc.enable = 1'b0;
        reset      = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 128'd0;
        for (int i = 0; i < 256; i++) h[i] = 32'd0;
        repeat (3) tick();
        chk("rst_rd_addr", ifc.cdf_sc_mem_rd_addr, 0);
        chk("rst_wt_addr", ifc.cdf_sc_mem_wt_addr, 0);
        chk("rst_wt_data", ifc.cdf_sc_mem_wt_data, 0);
        chk("rst_wt_en",   ifc.cdf_sc_mem_wt_en, 0);
        chk("rst_busy",    ifc.busy, 0);
        chk("rst_wt_done", ifc.cdf_sc_mem_wt_done, 0);
        chk("rst_cdf_min", ifc.cdf_min, 0);
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 256; i++) h[i] = 32'd1;
        run("ones", 0, 0, 0, 32'd1);

        for (int i = 0; i < 256; i++) h[i] = 32'd0;
        h[10] = 32'd5; h[200] = 32'd7;
        run("sparse", 0, 0, 0, 32'd5);

        for (int i = 0; i < 256; i++) h[i] = 32'd0;
        run("zero", 0, 0, 0, 32'd0);

        for (int i = 0; i < 256; i++) h[i] = 32'd1;
        run("midreset", 0, 0, 50, 32'd0);
        run("rerun", 0, 0, 0, 32'd1);

        for (int i = 0; i < 256; i++) h[i] = 32'(i % 7);
        run("ignore_en", 20, 100, 0, 32'd1);

        for (int i = 0; i < 256; i++) h[i] = 32'd0;
        h[0] = 32'hFFFF_FFFF; h[1] = 32'd2;
        run("wrap", 0, 0, 0, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cdf_accumulator.md
# cdf_accumulator

Histogram-equalization stage directly upstream of the divider. On a start pulse it reads the 256-bin pixel histogram from scratch memory four bins per 128-bit word and computes the running cumulative sum (CDF). It writes the CDF back to scratch memory in the same packing and reports `cdf_min`, the first non-zero CDF value, which the divider consumes together with the written CDF words.

## Interface
- `HIST_BASE`, default 16'h0000: scratch word address of histogram word 0.
- `CDF_BASE`, default 16'h0040: scratch word address of CDF word 0.
- `NUM_WORDS`, default 64: histogram length in 128-bit words; 4 bins per word.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: start request; sampled only in IDLE.
- `cdf_sc_mem_rd_addr` output 16: scratch read address; uses read port 1.
- `cdf_sc_mem_rd_data` input 128: scratch read data; lane k = bits [32k+31:32k] = bin 4·word+k.
- `cdf_sc_mem_wt_addr` output 16: scratch write address.
- `cdf_sc_mem_wt_data` output 128: CDF word, same lane packing as the histogram.
- `cdf_sc_mem_wt_en` output 1: write strobe, one cycle per word.
- `busy` output 1: high from the cycle after start until `cdf_sc_mem_wt_done`.
- `cdf_sc_mem_wt_done` output 1: one-cycle pulse after the last word is written.
- `cdf_min` output 32: first non-zero CDF value; 0 if the histogram is all zero.

## Operation
- FSM states: IDLE, READ, ACC, WRITE, DONE.
- IDLE, `enable`=1: clear the running sum, word index and `found` flag; set `cdf_min` to 0; go to READ.
- READ: drive `rd_addr = HIST_BASE + idx`; go to ACC.
- ACC: capture `rd_data`.
  - Compute lane prefix sums: c0=sum+h0, c1=c0+h1, c2=c1+h2, c3=c2+h3.
  - Register {c3,c2,c1,c0} into `wt_data`, `CDF_BASE+idx` into `wt_addr`, and c3 into `sum`.
  - If `found`=0, load the lowest-index non-zero c_k into `cdf_min` and set `found`.
  - Go to WRITE.
- WRITE: `wt_en`=1.
  - If idx = NUM_WORDS-1, go to DONE; otherwise idx+1 and go to READ.
- DONE: `wt_done`=1 for one cycle; go to IDLE.
- Arithmetic: 32-bit unsigned with modulo-2^32 wrap and no saturation. Addresses are 16-bit with modulo wrap.
- `cdf_min` holds its value in IDLE until the next accepted start.
- `enable` is ignored in READ/ACC/WRITE/DONE; no queuing.
- `enable` held high through DONE restarts one cycle later from IDLE.

## Timing
- Scratch memory read latency: data addressed in READ is valid for sampling at the end of ACC, one cycle later.
- Per word: 3 cycles, exactly one write.
- Start: `enable` is sampled at edge E0; READ for word 0 is the cycle after E0.
- First `wt_en` is in cycle E0+3.
- `wt_done` is in cycle E0+3·NUM_WORDS+1 (E0+193 at default).
- `busy` is high in cycles E0+1 .. E0+3·NUM_WORDS.
- Reset values: `rd_addr`=0, `wt_addr`=0, `wt_data`=0, `wt_en`=0, `busy`=0, `wt_done`=0, `cdf_min`=0, state IDLE.
- Reset mid-operation: the FSM is in IDLE on the next cycle. No further `wt_en`, no `wt_done`. Already-written CDF words are left as written.
- `wt_en` is never asserted outside WRITE.
- `rd_addr` and `wt_addr` are never equal while `wt_en`=1 (distinct regions).

## Test plan
- Every bin = 1, pulse `enable` -> CDF word k = {4k+4, 4k+3, 4k+2, 4k+1} (lane3..lane0); last word = {256,255,254,253}; `cdf_min`=1; `wt_done` at E0+193; 64 `wt_en` pulses total.
- Bins all 0 except bin 10=5 and bin 200=7 -> bins 0–9 = 0, bins 10–199 = 5, bins 200–255 = 12; `cdf_min`=5.
- All-zero histogram -> all 64 CDF words are 0; `cdf_min`=0; `wt_done` still pulses at E0+193.
- `reset` asserted at E0+50 for one cycle -> no `wt_en` from E0+51 on; `busy`=0; `wt_done` never pulses. A re-pulse of `enable` then produces correct full results.
- `enable` re-pulsed at E0+20 and E0+100 -> ignored; exactly 64 writes; a single `wt_done`.
- Bin 0 = 32'hFFFFFFFF, bin 1 = 2 -> lane1 of word 0 = 32'h00000001 (wrap); `cdf_min` = 32'hFFFFFFFF.
